// File: rtl/sha256_round_ctrl.sv
// SHA-256 block controller: owns a..h, K ROM, 16-word W window and H0..H7; drives external T1/T2 datapaths.
// Latency: run at cycle N -> words N+1..N+16, rounds N+17..N+80, FINAL N+81, digest_valid from N+82.
// Backpressure: msg_valid low stalls LOAD; digest held until digest_ready. SHA256_CHAIN_EN lets first=0 chain from H.
module sha256_round_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                first,
    input  logic                msg_valid,
    output logic                msg_ready,
    input  logic [DATA_W-1:0]   msg_data,
    output logic [DATA_W-1:0]   e_o,
    output logic [DATA_W-1:0]   f_o,
    output logic [DATA_W-1:0]   g_o,
    output logic [DATA_W-1:0]   h_o,
    output logic [DATA_W-1:0]   k_o,
    output logic [DATA_W-1:0]   w_o,
    output logic [DATA_W-1:0]   a_o,
    output logic [DATA_W-1:0]   b_o,
    output logic [DATA_W-1:0]   c_o,
    input  logic [DATA_W-1:0]   t1_i,
    input  logic [DATA_W-1:0]   t2_i,
    output logic                dp_run,
    output logic                busy,
    output logic [8*DATA_W-1:0] digest,
    output logic                digest_valid,
    input  logic                digest_ready
);
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, OUT} state_t;

    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [0:63][31:0] K_ROM = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t             state, state_nxt;
    logic [31:0]        wv  [8];   // working variables, 0 = a .. 7 = h
    logic [31:0]        hs  [8];
    logic [31:0]        win [16];
    logic [3:0]         load_cnt;
    logic [5:0]         rnd_cnt;
    logic [255:0]       digest_q;
    logic [0:7][31:0]   h_sum;
    logic [31:0]        w_next;
    logic               use_iv;

`ifdef SHA256_CHAIN_EN
    assign use_iv = first;
`else
    assign use_iv = 1'b1;
    logic unused_first;
    assign unused_first = first;
`endif

    assign w_next = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];

    always_comb begin
        for (int i = 0; i < 8; i++) h_sum[i] = hs[i] + wv[i];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        msg_ready    = 1'b0;
        dp_run       = 1'b0;
        busy         = 1'b1;
        digest_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (run) state_nxt = LOAD;
            end
            LOAD: begin
                msg_ready = 1'b1;
                if (msg_valid && load_cnt == 4'd15) state_nxt = ROUND;
            end
            ROUND: begin
                dp_run = 1'b1;
                if (rnd_cnt == 6'd63) state_nxt = FINAL;
            end
            FINAL: state_nxt = OUT;
            OUT: begin
                digest_valid = 1'b1;
                if (digest_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                wv[i] <= '0;
                hs[i] <= IV[i];
            end
            for (int i = 0; i < 16; i++) win[i] <= '0;
            load_cnt <= '0;
            rnd_cnt  <= '0;
            digest_q <= IV;
        end else begin
            case (state)
                IDLE: if (run) begin
                    load_cnt <= '0;
                    for (int i = 0; i < 8; i++) begin
                        wv[i] <= use_iv ? IV[i] : hs[i];
                        if (use_iv) hs[i] <= IV[i];
                    end
                end
                LOAD: if (msg_valid) begin
                    for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                    win[15]  <= msg_data;
                    load_cnt <= load_cnt + 4'd1;
                    rnd_cnt  <= '0;
                end
                ROUND: begin
                    wv[7] <= wv[6];
                    wv[6] <= wv[5];
                    wv[5] <= wv[4];
                    wv[4] <= wv[3] + t1_i;
                    wv[3] <= wv[2];
                    wv[2] <= wv[1];
                    wv[1] <= wv[0];
                    wv[0] <= t1_i + t2_i;
                    for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                    win[15] <= w_next;
                    rnd_cnt <= rnd_cnt + 6'd1;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) hs[i] <= h_sum[i];
                    digest_q <= h_sum;
                end
                default: ;
            endcase
        end
    end

    assign a_o    = wv[0];
    assign b_o    = wv[1];
    assign c_o    = wv[2];
    assign e_o    = wv[4];
    assign f_o    = wv[5];
    assign g_o    = wv[6];
    assign h_o    = wv[7];
    assign k_o    = (state == ROUND) ? K_ROM[rnd_cnt] : K_ROM[0];
    assign w_o    = win[0];
    assign digest = digest_q;
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: plain SHA-256 reference compression plus per-cycle output compare.
module tb_sha256_round_ctrl;
    logic clk = 1'b0, rst = 1'b1, run = 1'b0, first = 1'b0, msg_valid = 1'b0, digest_ready = 1'b0;
    logic [31:0] msg_data = 32'h0;
    logic msg_ready, dp_run, busy, digest_valid;
    logic [31:0] a_o, b_o, c_o, e_o, f_o, g_o, h_o, k_o, w_o, t1_i, t2_i;
    logic [255:0] digest;
    int n_checks = 0, n_err = 0, ec = 0;

    localparam logic [255:0] IV_ALL    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_ROUND = 2, PH_FINAL = 3, PH_OUT = 4;

    logic [31:0] IVW [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bs0(input logic [31:0] x); return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22); endfunction
    function automatic logic [31:0] bs1(input logic [31:0] x); return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25); endfunction
    function automatic logic [31:0] ss0(input logic [31:0] x); return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3); endfunction
    function automatic logic [31:0] ss1(input logic [31:0] x); return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10); endfunction
    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction
    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction
    function automatic logic [255:0] pack8(input logic [31:0] x [8]);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = x[i];
        return r;
    endfunction

    sha256_round_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .first(first),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
        .e_o(e_o), .f_o(f_o), .g_o(g_o), .h_o(h_o), .k_o(k_o), .w_o(w_o),
        .a_o(a_o), .b_o(b_o), .c_o(c_o), .t1_i(t1_i), .t2_i(t2_i),
        .dp_run(dp_run), .busy(busy), .digest(digest),
        .digest_valid(digest_valid), .digest_ready(digest_ready)
    );

    // External T1/T2 round datapaths
    assign t1_i = h_o + bs1(e_o) + ch(e_o, f_o, g_o) + k_o + w_o;
    assign t2_i = bs0(a_o) + maj(a_o, b_o, c_o);

    always #5 clk = ~clk;
    always @(posedge clk) ec <= ec + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, exp, ec);
        end
    endtask

    // Reference model state
    int m_ph = PH_IDLE, m_n = 0, m_t = 0;
    bit m_known = 1'b0, m_wzero = 1'b0;
    logic [31:0] m_h [8], m_v [8], m_dig [8], m_words [16];
    logic [31:0] tr_w [64];
    logic [31:0] tr_v [65][8];

    task automatic build_trace();
        logic [31:0] w [64];
        logic [31:0] x [8];
        logic [31:0] t1, t2;
        for (int i = 0; i < 16; i++) w[i] = m_words[i];
        for (int i = 16; i < 64; i++) w[i] = ss1(w[i-2]) + w[i-7] + ss0(w[i-15]) + w[i-16];
        for (int i = 0; i < 8; i++) begin x[i] = m_v[i]; tr_v[0][i] = x[i]; end
        for (int t = 0; t < 64; t++) begin
            t1 = x[7] + bs1(x[4]) + ch(x[4], x[5], x[6]) + KT[t] + w[t];
            t2 = bs0(x[0]) + maj(x[0], x[1], x[2]);
            x[7] = x[6]; x[6] = x[5]; x[5] = x[4]; x[4] = x[3] + t1;
            x[3] = x[2]; x[2] = x[1]; x[1] = x[0]; x[0] = t1 + t2;
            tr_w[t] = w[t];
            for (int i = 0; i < 8; i++) tr_v[t+1][i] = x[i];
        end
    endtask

    // Compare against the model, then advance it with the inputs the next edge will sample
    initial begin
        bit chain;
        forever begin
            @(negedge clk);
            if (m_known) begin
                chk("ctrl", 256'({busy, msg_ready, dp_run, digest_valid}),
                    256'({m_ph != PH_IDLE, m_ph == PH_LOAD, m_ph == PH_ROUND, m_ph == PH_OUT}));
                chk("vars", {a_o, b_o, c_o, 32'(wv_d()), e_o, f_o, g_o, h_o}, pack8(m_v));
                chk("digest", digest, pack8(m_dig));
                chk("k", 256'(k_o), 256'(m_ph == PH_ROUND ? KT[m_t] : KT[0]));
                if (m_ph == PH_ROUND) chk("w", 256'(w_o), 256'(tr_w[m_t]));
                else if (m_wzero) chk("w_reset", 256'(w_o), 256'(0));
            end
            if (rst) begin
                m_known = 1'b1; m_ph = PH_IDLE; m_wzero = 1'b1; m_t = 0;
                for (int i = 0; i < 8; i++) begin m_h[i] = IVW[i]; m_v[i] = 0; m_dig[i] = IVW[i]; end
            end else if (m_known) begin
                case (m_ph)
                    PH_IDLE: if (run) begin
`ifdef SHA256_CHAIN_EN
                        chain = !first;
`else
                        chain = 1'b0;
`endif
                        for (int i = 0; i < 8; i++) begin
                            if (!chain) m_h[i] = IVW[i];
                            m_v[i] = m_h[i];
                        end
                        m_ph = PH_LOAD; m_n = 0;
                    end
                    PH_LOAD: if (msg_valid) begin
                        m_words[m_n] = msg_data; m_n++; m_wzero = 1'b0;
                        if (m_n == 16) begin build_trace(); m_ph = PH_ROUND; m_t = 0; end
                    end
                    PH_ROUND: begin
                        for (int i = 0; i < 8; i++) m_v[i] = tr_v[m_t+1][i];
                        m_t++;
                        if (m_t == 64) m_ph = PH_FINAL;
                    end
                    PH_FINAL: begin
                        for (int i = 0; i < 8; i++) begin m_h[i] = m_h[i] + m_v[i]; m_dig[i] = m_h[i]; end
                        m_ph = PH_OUT;
                    end
                    PH_OUT: if (digest_ready) m_ph = PH_IDLE;
                    default: m_ph = PH_IDLE;
                endcase
            end
        end
    end

    // d is not a port; the model's d is compared through the e update instead
    function automatic logic [31:0] wv_d();
        return m_v[3];
    endfunction

    logic [31:0] blk [16];

    task automatic set_blk(input int kind);
        logic [7:0] c;
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        case (kind)
            0: begin blk[0] = 32'h61626380; blk[15] = 32'h18; end
            1: blk[0] = 32'h80000000;
            2: begin
                for (int i = 0; i < 14; i++) begin
                    c = 8'h61 + 8'(i);
                    blk[i] = {c, c + 8'd1, c + 8'd2, c + 8'd3};
                end
                blk[14] = 32'h80000000;
            end
            3: blk[15] = 32'h1c0;
            default: for (int i = 0; i < 16; i++) blk[i] = $urandom;
        endcase
    endtask

    // gap: 0 valid always, 1 valid every other cycle, 2 random valid
    task automatic start_block(input bit fst, input int gap, input bit noise, output int n_run);
        int j, idx;
        bit hs;
        @(posedge clk); #1;
        run = 1'b1; first = fst;
        @(negedge clk);
        n_run = ec;
        @(posedge clk); #1;
        run = 1'b0; first = 1'($urandom % 2);
        j = 0; idx = 0;
        while (idx < 16 && j < 400) begin
            msg_valid = (gap == 0) ? 1'b1 : (gap == 1) ? 1'(j % 2) : 1'($urandom % 2);
            msg_data  = blk[idx];
            run       = noise && (j == 3);
            @(negedge clk);
            hs = msg_valid && msg_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            j++;
        end
        msg_valid = 1'b0; run = 1'b0;
        chk("words_accepted", 256'(idx), 256'(16));
    endtask

    task automatic finish_block(input int n_run, input logic [255:0] lit, input bit use_lit,
                                input int exp_lat, input int hold, input bit noise);
        int k;
        k = 0;
        @(negedge clk);
        while (!digest_valid && k < 300) begin
            @(posedge clk); #1;
            run = noise && (k == 10);
            digest_ready = noise && (k == 12);
            @(negedge clk);
            k++;
        end
        chk("digest_valid_seen", 256'(digest_valid), 256'(1));
        if (exp_lat >= 0) chk("latency", 256'(ec - n_run), 256'(exp_lat));
        if (use_lit) chk("digest_value", digest, lit);
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", 256'(digest_valid), 256'(1));
            if (use_lit) chk("hold_digest", digest, lit);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1; run = 1'b0; digest_ready = 1'b1;
        @(posedge clk); #1; digest_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_ack", 256'(busy), 256'(0));
    endtask

    initial begin
        int n_run;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 256'(busy), 256'(0));
        chk("reset_ready", 256'({msg_ready, dp_run, digest_valid}), 256'(0));
        chk("reset_digest", digest, IV_ALL);
        chk("reset_vars", {a_o, b_o, c_o, e_o, f_o, g_o, h_o, w_o}, 256'(0));

        set_blk(0); start_block(1'b1, 0, 1'b0, n_run); finish_block(n_run, ABC_DIG, 1'b1, 82, 0, 1'b0);
        set_blk(1); start_block(1'b1, 0, 1'b0, n_run); finish_block(n_run, EMPTY_DIG, 1'b1, 82, 0, 1'b0);
        set_blk(0); start_block(1'b1, 1, 1'b0, n_run); finish_block(n_run, ABC_DIG, 1'b1, 98, 5, 1'b0);
        set_blk(0); start_block(1'b1, 0, 1'b1, n_run); finish_block(n_run, ABC_DIG, 1'b1, 82, 2, 1'b1);

        set_blk(2); start_block(1'b1, 0, 1'b0, n_run); finish_block(n_run, 256'(0), 1'b0, 82, 0, 1'b0);
        set_blk(3); start_block(1'b0, 0, 1'b0, n_run);
`ifdef SHA256_CHAIN_EN
        finish_block(n_run, TWO_DIG, 1'b1, 82, 0, 1'b0);
`else
        finish_block(n_run, 256'(0), 1'b0, 82, 0, 1'b0);
        n_checks++;
        if (digest === TWO_DIG) begin
            n_err++;
            $display("FAIL chain_off_differs: got %0h required a value other than that", digest);
        end
`endif

        set_blk(0); start_block(1'b1, 0, 1'b0, n_run);
        repeat (30) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_no_digest", 256'(digest_valid), 256'(0));
        chk("rst_digest_iv", digest, IV_ALL);
        set_blk(0); start_block(1'b1, 0, 1'b0, n_run); finish_block(n_run, ABC_DIG, 1'b1, 82, 1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            set_blk(9);
            start_block(1'($urandom % 2), 2, 1'($urandom % 2), n_run);
            finish_block(n_run, 256'(0), 1'b0, -1, int'($urandom_range(3, 0)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
- Sequences the 64 compression rounds of one SHA-256 512-bit block around the external T1 and T2 round datapaths.
- Owns the working variables a..h, the K-constant ROM, the 16-word W expansion window and the hash state H0..H7.
- Streams in message words, presents e/f/g/h/K/W to T1 and a/b/c to T2, consumes t1/t2 and emits the 256-bit digest.

Parameters:
DATA_W, 32, word width; fixed, only 32 is legal.

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock, synchronous, active-high
run  input  1  start pulse; sampled only in IDLE
first  input  1  sampled with run: 1 = start from IV, 0 = chain from current H (see Optional Feature)
msg_valid  input  1  message word valid
msg_ready  output  1  controller accepts word
msg_data  input  32  message word, W0 first, big-endian word order
e_o, f_o, g_o  output  32 each  to T1 in0/in1/in2
h_o  output  32  to T1 in3 path
k_o  output  32  K[t] to T1
w_o  output  32  W[t] to T1
a_o, b_o, c_o  output  32 each  to T2
t1_i  input  32  T1 result; combinational, same cycle
t2_i  input  32  T2 result; combinational, same cycle
dp_run  output  1  high in ROUND; drives datapath run
busy  output  1  high in any state except IDLE
digest  output  256  H0 in [255:224] .. H7 in [31:0]
digest_valid  output  1  digest available
digest_ready  input  1  consumer ack

Behaviour:
- FSM states: IDLE, LOAD, ROUND, FINAL, OUT.
- Reset: state IDLE; H0..H7 = SHA-256 IV; a..h, window and counters 0; msg_ready, dp_run, busy, digest_valid = 0; digest bus = IV.
- Reset mid-operation abandons the block and restarts from this reset state; no partial digest is emitted.
- IDLE: run=1 moves to LOAD next cycle and copies the start value into a..h. The start value is IV if first=1 (or the macro is absent), otherwise current H. If first=1, H is also loaded with IV. run in any other state is ignored.
- LOAD: msg_ready=1. Each msg_valid&&msg_ready shifts msg_data into window[15]; window[i] <= window[i+1]. A 4-bit counter runs 0..15; after the 16th word the FSM enters ROUND and the round counter is cleared. With valid low, nothing changes.
- ROUND: dp_run=1; one round per cycle; t = round counter 0..63.
- ROUND outputs: k_o = K[t] from internal 64-entry ROM; w_o = window[0].
- Register update each ROUND cycle:
  - h<=g, g<=f, f<=e, e<=d+t1_i, d<=c, c<=b, b<=a, a<=t1_i+t2_i.
  - window shifts down by one; window[15] <= sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0].
  - sigma0 = ROTR7^ROTR18^SHR3; sigma1 = ROTR17^ROTR19^SHR10.
- All additions are modulo 2^32; carries are discarded.
- After t=63 the FSM enters FINAL.
- FINAL: one cycle; Hi <= Hi + working var i (mod 2^32, i = 0..7); next state OUT.
- OUT: digest_valid=1 and digest = H. Both are held stable until digest_ready=1; then IDLE next cycle. digest_ready while not valid is ignored.
- Outputs outside their states:
  - e_o..h_o and a_o..c_o always reflect the registers.
  - k_o = K[0] outside ROUND.
  - msg_ready = 0 outside LOAD.
- Latency: run accepted at cycle N with msg_valid held high gives:
  - words accepted N+1..N+16
  - ROUND N+17..N+80
  - FINAL N+81
  - digest_valid from N+82
- The digest bus keeps its last value after the handshake until the next FINAL.

Optional Feature:
- Macro SHA256_CHAIN_EN.
- Defined: first=0 with run chains from the previous H, enabling multi-block messages.
- Undefined: first is ignored; every block starts from IV and H is reloaded with IV at every accepted run.

Test Plan:
- "abc" padded single block, first=1, valid always high:
  - digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad
  - digest_valid exactly 82 cycles after run.
- Empty-message padded block: digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- SHA256_CHAIN_EN: two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", first=1 then first=0:
  - final digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1
  - without the macro, block 2 starts from IV and the result differs.
- Backpressure on "abc":
  - msg_valid toggled every other cycle: same digest, ROUND entry delayed accordingly.
  - digest_ready held 0 for 5 cycles: digest and digest_valid stable throughout; IDLE one cycle after ready.
- run pulsed during LOAD/ROUND is ignored with no digest change.
- rst asserted at round 30: busy=0 next cycle. A fresh "abc" run then gives the correct digest.
